// File: rtl/dmau_pkg.sv
// Shared definitions for the data memory access unit: FSM states, RV32I
// load/store width codes and access-size helpers.
package dmau_pkg;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ISSUE     = 2'd1;
  localparam logic [1:0] WAIT_READ = 2'd2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Latched request fields still needed after the bus strobe is issued.
  typedef struct packed {
    logic       is_read;
    logic [2:0] funct3;
    logic [1:0] off;
  } dmau_req_t;

  // Reserved codes fall through to word size.
  function automatic logic [1:0] access_size(input logic [2:0] f3, input logic is_read);
    if (f3 == F3_B || (is_read && f3 == F3_BU)) return SZ_B;
    if (f3 == F3_H || (is_read && f3 == F3_HU)) return SZ_H;
    return SZ_W;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_H:    return off[0];
      SZ_W:    return |off;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_data_extractor.sv
// Picks the addressed byte/half out of a bus word and sign/zero-extends it
// according to the load funct3; reserved codes pass the word through.
module load_data_extractor
  import dmau_pkg::*;
(
  input  logic [31:0] raw_word,
  input  logic [1:0]  byte_offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    lane_byte = raw_word[{byte_offset, 3'b000} +: 8];
    lane_half = byte_offset[1] ? raw_word[31:16] : raw_word[15:0];
    case (funct3)
      F3_B:    result = {{24{lane_byte[7]}}, lane_byte};
      F3_H:    result = {{16{lane_half[15]}}, lane_half};
      F3_BU:   result = {24'h0, lane_byte};
      F3_HU:   result = {16'h0, lane_half};
      default: result = raw_word;
    endcase
  end

endmodule

// File: rtl/data_memory_access_unit.sv
// Load/store front end between the core memory stage and the data bus.
// Define MISALIGNED_TRAP_EN to fault misaligned half/word accesses instead of issuing them.
module data_memory_access_unit
  import dmau_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        core_read,
  input  logic        core_write,
  input  logic [31:0] core_address,
  input  logic [31:0] core_write_data,
  input  logic [2:0]  core_funct3,
  output logic        core_stall,
  output logic [31:0] core_read_data,
  output logic        core_done,
  output logic        misaligned_fault,
  output logic [31:0] bus_address,
  output logic [31:0] bus_write_data,
  output logic [3:0]  bus_byte_enable,
  output logic        bus_read_enable,
  output logic        bus_write_enable,
  input  logic        bus_wait_req,
  input  logic        bus_valid,
  input  logic [31:0] bus_read_data
);

  logic [1:0]  state;
  dmau_req_t   req_q;
  logic        accept, trap;
  logic [1:0]  size;
  logic [3:0]  st_be;
  logic [31:0] st_data, ld_ext;

  // core_done blocks re-acceptance of the request the core is still holding.
  assign core_stall = (core_read | core_write) && !core_done;
  assign accept     = core_stall && (state == IDLE);
  assign size       = access_size(core_funct3, core_read);

`ifdef MISALIGNED_TRAP_EN
  assign trap = is_misaligned(size, core_address[1:0]);
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    st_be   = 4'b1111;
    st_data = '0;
    if (!core_read) begin
      case (size)
        SZ_B: begin
          st_be   = 4'b0001 << core_address[1:0];
          st_data = {4{core_write_data[7:0]}};
        end
        SZ_H: begin
          st_be   = core_address[1] ? 4'b1100 : 4'b0011;
          st_data = {2{core_write_data[15:0]}};
        end
        default: st_data = core_write_data;
      endcase
    end
  end

  assign bus_read_enable  = (state == ISSUE) &&  req_q.is_read;
  assign bus_write_enable = (state == ISSUE) && !req_q.is_read;

  load_data_extractor u_extract (
    .raw_word    (bus_read_data),
    .byte_offset (req_q.off),
    .funct3      (req_q.funct3),
    .result      (ld_ext)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      req_q            <= '0;
      core_done        <= 1'b0;
      misaligned_fault <= 1'b0;
      core_read_data   <= '0;
      bus_address      <= '0;
      bus_write_data   <= '0;
      bus_byte_enable  <= '0;
    end else begin
      core_done        <= 1'b0;
      misaligned_fault <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          if (trap) begin
            core_done        <= 1'b1;
            misaligned_fault <= 1'b1;
            core_read_data   <= '0;
          end else begin
            req_q           <= '{is_read: core_read, funct3: core_funct3, off: core_address[1:0]};
            bus_address     <= {core_address[31:2], 2'b00};
            bus_write_data  <= st_data;
            bus_byte_enable <= st_be;
            state           <= ISSUE;
          end
        end
        ISSUE: if (!bus_wait_req) begin
          if (req_q.is_read) begin
            state <= WAIT_READ;
          end else begin
            core_done <= 1'b1;
            state     <= IDLE;
          end
        end
        WAIT_READ: if (bus_valid) begin
          core_read_data <= ld_ext;
          core_done      <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
